multi_voice_player: RTL and testbench

// - Time-multiplexed N-voice successor to the single-voice clip player.
// - Per-voice fractional phase accumulator, loop or one-shot playback.
// - Reads one shared clip RAM (1-cycle read latency); mixes all voices into one saturated int16 sample per sample_tick.
// - Sits between the clip RAM and the I2S transmitter; a control master (PS/AXI shim) sets voices via a note handshake.

---
 rtl/multi_voice_player.sv | 198 +++++++++++++++++++
 tb/tb_multi_voice_player.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_voice_player.sv
// Time-multiplexed N-voice clip player: fractional phase per voice, loop/one-shot, saturating mix.
// Define PLAYER_LERP_EN for linear interpolation (3 cycles/voice); default is nearest-lower sample (2 cycles/voice).
module multi_voice_player #(
    parameter  int CLIP_LEN   = 1024,
    parameter  int NUM_VOICES = 4,
    parameter  int INC_W      = 16,
    parameter  int FRAC_BITS  = 12,
    localparam int AW         = $clog2(CLIP_LEN),
    localparam int PW         = AW + FRAC_BITS,
    localparam int VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  sample_tick,
    output logic [AW-1:0]         rd_addr,
    input  logic signed [15:0]    rd_data,
    input  logic                  note_valid,
    output logic                  note_ready,
    input  logic [VW-1:0]         note_voice,
    input  logic                  note_on,
    input  logic [INC_W-1:0]      note_inc,
    input  logic                  note_oneshot,
    output logic signed [15:0]    mix_sample,
    output logic                  mix_valid,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  overrun
);

    localparam int ACC_W = 16 + $clog2(NUM_VOICES) + 1;
    localparam int SUM_W = ((PW > INC_W) ? PW : INC_W) + 1;
    localparam logic [SUM_W-1:0]        PHASE_END = SUM_W'(CLIP_LEN) << FRAC_BITS;
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = ACC_W'(-32768);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_CALC,
        S_OUT
    } state_t;

    state_t                  state;
    logic [VW-1:0]           v;
    logic signed [ACC_W-1:0] acc;
    logic [PW-1:0]           phase [NUM_VOICES];
    logic [INC_W-1:0]        inc   [NUM_VOICES];
    logic [NUM_VOICES-1:0]   oneshot;

    logic                    note_fire;
    logic [PW-1:0]           cur_phase;
    logic [AW-1:0]           idx0;
    logic [VW-1:0]           nxt_v;
    logic [AW-1:0]           nxt_idx;
    logic                    last_voice;
    logic signed [16:0]      interp;
    logic signed [ACC_W-1:0] contrib;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [15:0]      sat_sample;
    logic [SUM_W-1:0]        phase_sum;

    assign note_ready = (state == S_IDLE);
    assign note_fire  = note_valid && note_ready;
    assign cur_phase  = phase[v];
    assign last_voice = (v == VW'(NUM_VOICES - 1));

    // A note for voice 0 in the tick cycle must already steer the first read address.
    assign idx0 = (note_fire && note_on && note_voice == '0) ? '0 : phase[0][PW-1:FRAC_BITS];

    always_comb begin
        nxt_v   = v + VW'(1);
        nxt_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (nxt_v == VW'(i)) nxt_idx = phase[i][PW-1:FRAC_BITS];
        end
    end

`ifdef PLAYER_LERP_EN
    localparam int PROD_W = 18 + FRAC_BITS;

    logic signed [15:0]       s0_q;
    logic signed [15:0]       s1;
    logic [AW-1:0]            cur_idx;
    logic [FRAC_BITS-1:0]     cur_frac;
    logic signed [16:0]       diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] step;

    always_comb begin
        cur_idx  = cur_phase[PW-1:FRAC_BITS];
        cur_frac = cur_phase[FRAC_BITS-1:0];
        // One-shot voices never blend the last sample with the start of the clip.
        s1       = (oneshot[v] && cur_idx == AW'(CLIP_LEN - 1)) ? s0_q : rd_data;
        diff     = 17'(s1) - 17'(s0_q);
        prod     = PROD_W'(diff) * PROD_W'($signed({1'b0, cur_frac}));
        step     = prod >>> FRAC_BITS;
        interp   = 17'(s0_q) + $signed(step[16:0]);
    end
`else
    always_comb begin
        interp = 17'(rd_data);
    end
`endif

    always_comb begin
        contrib   = voice_active[v] ? ACC_W'(interp) : '0;
        acc_sum   = acc + contrib;
        phase_sum = SUM_W'(cur_phase) + SUM_W'(inc[v]);
        if (acc_sum > SAT_MAX)      sat_sample = 16'sh7fff;
        else if (acc_sum < SAT_MIN) sat_sample = 16'sh8000;
        else                        sat_sample = acc_sum[15:0];
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            v            <= '0;
            acc          <= '0;
            rd_addr      <= '0;
            mix_sample   <= '0;
            mix_valid    <= 1'b0;
            overrun      <= 1'b0;
            voice_active <= '0;
            oneshot      <= '0;
            // NOTE: the per-voice arrays are a handful of flops, not a RAM, so they take the reset too.
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
                inc[i]   <= '0;
            end
`ifdef PLAYER_LERP_EN
            s0_q         <= '0;
`endif
        end else begin
            mix_valid <= 1'b0;
            if (sample_tick && state != S_IDLE) overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (note_fire) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (note_voice == VW'(i)) begin
                                inc[i]          <= note_inc;
                                oneshot[i]      <= note_oneshot;
                                voice_active[i] <= note_on;
                                if (note_on) phase[i] <= '0;
                            end
                        end
                    end
                    if (sample_tick) begin
                        acc     <= '0;
                        v       <= '0;
                        rd_addr <= idx0;
                        state   <= S_RD0;
                    end
                end

`ifdef PLAYER_LERP_EN
                S_RD0: begin
                    rd_addr <= cur_idx + AW'(1);
                    state   <= S_RD1;
                end

                S_RD1: begin
                    s0_q  <= rd_data;
                    state <= S_CALC;
                end
`else
                S_RD0: state <= S_CALC;
`endif

                S_CALC: begin
                    acc <= acc_sum;
                    if (voice_active[v]) begin
                        if (oneshot[v] && phase_sum >= PHASE_END) begin
                            voice_active[v] <= 1'b0;
                            phase[v]        <= '0;
                        end else begin
                            phase[v] <= phase_sum[PW-1:0];
                        end
                    end
                    if (last_voice) begin
                        mix_sample <= sat_sample;
                        mix_valid  <= 1'b1;
                        state      <= S_OUT;
                    end else begin
                        v       <= nxt_v;
                        rd_addr <= nxt_idx;
                        state   <= S_RD0;
                    end
                end

                S_OUT:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_voice_player.sv
// Self-checking bench for multi_voice_player: constant vector table, hand-written corner sequences,
// and randomized notes/clip data checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_multi_voice_player;

    localparam int L   = 64;
    localparam int NV  = 2;
    localparam int IW  = 16;
    localparam int FB  = 12;
    localparam int AW  = 6;
    localparam int ONE = 1 << FB;
`ifdef PLAYER_LERP_EN
    localparam bit LERP = 1'b1;
`else
    localparam bit LERP = 1'b0;
`endif
    localparam int LAT = LERP ? 3 * NV + 1 : 2 * NV + 1;

    logic               mclk = 1'b0;
    logic               rst = 1'b1;
    logic               sample_tick = 1'b0;
    logic [AW-1:0]      rd_addr;
    logic signed [15:0] rd_data;
    logic               note_valid = 1'b0;
    logic               note_ready;
    logic [0:0]         note_voice = '0;
    logic               note_on = 1'b0;
    logic [IW-1:0]      note_inc = '0;
    logic               note_oneshot = 1'b0;
    logic signed [15:0] mix_sample;
    logic               mix_valid;
    logic [NV-1:0]      voice_active;
    logic               overrun;

    logic signed [15:0] clip [L];

    multi_voice_player #(
        .CLIP_LEN  (L),
        .NUM_VOICES(NV),
        .INC_W     (IW),
        .FRAC_BITS (FB)
    ) dut (
        .mclk        (mclk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_voice  (note_voice),
        .note_on     (note_on),
        .note_inc    (note_inc),
        .note_oneshot(note_oneshot),
        .mix_sample  (mix_sample),
        .mix_valid   (mix_valid),
        .voice_active(voice_active),
        .overrun     (overrun)
    );

    always #5 mclk = ~mclk;

    // Clip RAM with one cycle of read latency.
    always @(posedge mclk) rd_data <= clip[rd_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: voice positions held as plain integers in units of 1/ONE sample.
    longint m_pos [NV];
    int     m_inc [NV];
    bit     m_one [NV];
    bit     m_act [NV];

    function automatic longint floor_div(input longint a, input longint b);
        longint q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NV; k++) begin
            m_pos[k] = 0; m_inc[k] = 0; m_one[k] = 0; m_act[k] = 0;
        end
    endtask

    task automatic model_frame(output int exp);
        longint sum  = 0;
        longint span = longint'(L) * ONE;
        for (int k = 0; k < NV; k++) begin
            if (m_act[k]) begin
                int idx  = int'(m_pos[k] / ONE);
                int frac = int'(m_pos[k] % ONE);
                int a    = clip[idx];
                int b    = (m_one[k] && idx == L - 1) ? a : int'(clip[(idx + 1) % L]);
                sum += LERP ? a + floor_div(longint'(b - a) * frac, ONE) : longint'(a);
                m_pos[k] += m_inc[k];
                if (m_one[k] && m_pos[k] >= span) begin
                    m_act[k] = 0;
                    m_pos[k] = 0;
                end else begin
                    m_pos[k] = m_pos[k] % span;
                end
            end
        end
        exp = (sum > 32767) ? 32767 : (sum < -32768) ? -32768 : int'(sum);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < L; i++) clip[i] = 16'(16 * i);
    endtask

    task automatic load_const(input int val);
        for (int i = 0; i < L; i++) clip[i] = 16'(val);
    endtask

    task automatic do_reset();
        @(negedge mclk);
        rst = 1'b1; sample_tick = 1'b0; note_valid = 1'b0;
        repeat (2) @(negedge mclk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!note_ready && n < 50) begin
            @(negedge mclk);
            n++;
        end
        if (!note_ready) check("idle_timeout", note_ready, 1);
    endtask

    task automatic send_note(input int voice, input bit on, input int inc, input bit one);
        wait_idle();
        note_valid = 1'b1; note_voice = voice[0:0]; note_on = on;
        note_inc = inc[IW-1:0]; note_oneshot = one;
        @(negedge mclk);
        note_valid = 1'b0;
        m_inc[voice] = inc; m_one[voice] = one; m_act[voice] = on;
        if (on) m_pos[voice] = 0;
    endtask

    task automatic wait_valid(input string name);
        int n = 1;
        while (!mix_valid && n < 4 * LAT) begin
            @(negedge mclk);
            n++;
        end
        check(name, n, LAT);
    endtask

    task automatic run_frame(output int got);
        wait_idle();
        sample_tick = 1'b1;
        @(negedge mclk);
        sample_tick = 1'b0;
        wait_valid("latency");
        got = mix_sample;
    endtask

    task automatic frame_model(input string name);
        int got, exp;
        run_frame(got);
        model_frame(exp);
        check(name, got, exp);
    endtask

    task automatic frame_const(input string name, input int exp);
        int got, dummy;
        run_frame(got);
        model_frame(dummy);
        check(name, got, exp);
    endtask

    typedef struct {
        int inc;
        int exp_lerp;
        int exp_near;
    } vec_t;

    vec_t vecs [20];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp, pulses;

        vecs[0]  = '{ONE,         0,  0}; vecs[1]  = '{ONE,        16, 16};
        vecs[2]  = '{ONE,        32, 32}; vecs[3]  = '{ONE,        48, 48};
        vecs[4]  = '{ONE,        64, 64};
        vecs[5]  = '{ONE/2,       0,  0}; vecs[6]  = '{ONE/2,       8,  0};
        vecs[7]  = '{ONE/2,      16, 16}; vecs[8]  = '{ONE/2,      24, 16};
        vecs[9]  = '{ONE/2,      32, 32};
        vecs[10] = '{3*ONE/2,     0,  0}; vecs[11] = '{3*ONE/2,    24, 16};
        vecs[12] = '{3*ONE/2,    48, 48}; vecs[13] = '{3*ONE/2,    72, 64};
        vecs[14] = '{3*ONE/2,    96, 96};
        vecs[15] = '{ONE/4,       0,  0}; vecs[16] = '{ONE/4,       4,  0};
        vecs[17] = '{ONE/4,       8,  0}; vecs[18] = '{ONE/4,      12,  0};
        vecs[19] = '{ONE/4,      16, 16};

        load_ramp();
        model_clear();
        repeat (3) @(negedge mclk);
        rst = 1'b0;
        check("rst_mix_sample", mix_sample, 0);
        check("rst_mix_valid", mix_valid, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_voice_active", voice_active, 0);
        check("rst_overrun", overrun, 0);
        check("rst_note_ready", note_ready, 1);

        // Ramp clip, single looping voice, several increments.
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 0) begin
                do_reset();
                load_ramp();
                send_note(0, 1'b1, vecs[i].inc, 1'b0);
            end
            frame_const($sformatf("vec%0d", i), LERP ? vecs[i].exp_lerp : vecs[i].exp_near);
        end

        // Loop wrap at the clip end.
        do_reset(); load_ramp(); send_note(0, 1'b1, ONE, 1'b0);
        for (int i = 0; i < 63; i++) frame_model($sformatf("loop%0d", i));
        frame_const("loop_last", 1008);
        frame_const("loop_wrap", 0);
        check("loop_still_active", voice_active[0], 1);

        // One-shot, inc 2.0: last sample then silence.
        do_reset(); load_ramp(); send_note(0, 1'b1, 2 * ONE, 1'b1);
        for (int i = 0; i < 31; i++) frame_model($sformatf("os%0d", i));
        frame_const("os_last", 992);
        check("os_stopped", voice_active[0], 0);
        frame_const("os_silent", 0);

        // One-shot at idx 63, frac 0.5: the final sample is held rather than blended with idx 0.
        do_reset(); load_ramp(); send_note(0, 1'b1, ONE / 2, 1'b1);
        for (int i = 0; i < 127; i++) frame_model($sformatf("hold%0d", i));
        frame_const("hold_last", 1008);
        check("hold_stopped", voice_active[0], 0);

        // Note and tick in the same idle cycle: the frame sees the restarted phase.
        do_reset(); load_ramp(); send_note(0, 1'b1, ONE, 1'b0);
        for (int i = 0; i < 10; i++) frame_model($sformatf("pre%0d", i));
        wait_idle();
        note_valid = 1'b1; note_voice = '0; note_on = 1'b1; note_inc = IW'(ONE);
        note_oneshot = 1'b0; sample_tick = 1'b1;
        m_pos[0] = 0; m_inc[0] = ONE; m_one[0] = 0; m_act[0] = 1;
        @(negedge mclk);
        note_valid = 1'b0; sample_tick = 1'b0;
        wait_valid("note_tick_latency");
        model_frame(exp);
        check("note_tick_same", mix_sample, 0);
        frame_const("note_tick_next", 16);

        // Saturation with constant clips.
        do_reset(); load_const(30000);
        send_note(0, 1'b1, int'($urandom_range(0, 3 * ONE)), 1'b0);
        send_note(1, 1'b1, int'($urandom_range(0, 3 * ONE)), 1'b0);
        frame_const("sat_pos", 32767);
        load_const(-30000);
        frame_const("sat_neg", -32768);
        load_const(30000);
        send_note(1, 1'b0, ONE, 1'b0);
        frame_const("one_voice", 30000);
        check("one_voice_flags", voice_active, 2'b01);

        // Randomized notes and clip data against the model.
        do_reset();
        for (int i = 0; i < L; i++) clip[i] = 16'($urandom);
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0)
                send_note(int'($urandom_range(0, NV - 1)), $urandom_range(0, 4) != 0,
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                                      : int'($urandom_range(0, 3 * ONE)),
                          $urandom_range(0, 1) == 1);
            frame_model($sformatf("rand%0d", it));
        end

        // Tick while busy: flagged, ignored, exactly one output pulse.
        do_reset(); load_ramp(); send_note(0, 1'b1, ONE, 1'b0);
        wait_idle();
        pulses = 0;
        sample_tick = 1'b1;
        @(negedge mclk);
        sample_tick = 1'b0;
        check("busy_not_ready", note_ready, 0);
        if (mix_valid) pulses++;
        @(negedge mclk);
        sample_tick = 1'b1;
        if (mix_valid) pulses++;
        @(negedge mclk);
        sample_tick = 1'b0;
        if (mix_valid) pulses++;
        for (int k = 0; k < 4 * LAT; k++) begin
            @(negedge mclk);
            if (mix_valid) pulses++;
        end
        check("overrun_pulses", pulses, 1);
        check("overrun_flag", overrun, 1);
        model_frame(exp);
        check("overrun_sample", mix_sample, exp);
        frame_const("after_overrun", 16);
        check("overrun_sticky", overrun, 1);

        // Reset in the middle of a frame.
        wait_idle();
        sample_tick = 1'b1;
        @(negedge mclk);
        sample_tick = 1'b0;
        repeat (2) @(negedge mclk);
        check("midframe_busy", note_ready, 0);
        rst = 1'b1;
        #1;
        check("abort_mix_sample", mix_sample, 0);
        check("abort_mix_valid", mix_valid, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_voice_active", voice_active, 0);
        check("abort_overrun", overrun, 0);
        repeat (2) @(negedge mclk);
        rst = 1'b0;
        model_clear();
        pulses = 0;
        for (int k = 0; k < 4 * LAT; k++) begin
            @(negedge mclk);
            if (mix_valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        check("abort_ready", note_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
